// File: rtl/riscv_pkg.sv
// Shared RISC-V base-ISA constants: major opcodes and immediate format codes
// used by the decode front end.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_SH   = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: extracts the base-ISA immediate from a
// 32-bit instruction, classifies its format and flags unknown opcodes.
module imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0]         opc;
  logic [2:0]         funct3;
  logic signed [31:0] imm32;

  assign opc    = instr[6:0];
  assign funct3 = instr[14:12];

  // Every format is first built as a 32-bit signed value; the final cast
  // carries the sign up to XLEN (shamt is built with a zero MSB).
  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt   = FMT_SH;
          imm32 = {26'd0, (XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP, OPC_MISCMEM: begin
        fmt = FMT_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode plus PC-relative target ahead
// of a two-entry valid/ready skid buffer with synchronous flush.
module imm_gen_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic [XLEN-1:0] target_o,
  output logic            illegal_o
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  entry_t entry_p0;
  entry_t main_p1;
  entry_t skid_p1;
  logic   vld_main_p1;
  logic   vld_skid_p1;
  logic   accept;
  logic   pop;

  // Stage 0: decode and target adder, combinational from the inputs
  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr_i),
    .imm     (entry_p0.imm),
    .fmt     (entry_p0.fmt),
    .illegal (entry_p0.illegal)
  );

  assign entry_p0.target = pc_i + entry_p0.imm;

  assign accept = valid_i && ready_o;
  assign pop    = vld_main_p1 && ready_i;

  // Stage 1: main entry drives the outputs; skid only fills while main stalls
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_p1     <= '0;
      skid_p1     <= '0;
      vld_main_p1 <= 1'b0;
      vld_skid_p1 <= 1'b0;
    end else if (flush_i) begin
      vld_main_p1 <= 1'b0;
      vld_skid_p1 <= 1'b0;
    end else if (pop) begin
      if (vld_skid_p1) begin
        main_p1     <= skid_p1;
        vld_skid_p1 <= 1'b0;
      end else if (accept) begin
        main_p1 <= entry_p0;
      end else begin
        vld_main_p1 <= 1'b0;
      end
    end else if (accept) begin
      if (!vld_main_p1) begin
        main_p1     <= entry_p0;
        vld_main_p1 <= 1'b1;
      end else begin
        skid_p1     <= entry_p0;
        vld_skid_p1 <= 1'b1;
      end
    end
  end

  assign ready_o   = !vld_skid_p1;
  assign valid_o   = vld_main_p1;
  assign imm_o     = main_p1.imm;
  assign fmt_o     = main_p1.fmt;
  assign target_o  = main_p1.target;
  assign illegal_o = main_p1.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances driven in lockstep,
// directed cases followed by random traffic against a queue-based model.
module tb_imm_gen_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, vin, rdy;
  logic [31:0] instr;
  logic [31:0] pc32;
  logic [63:0] pc64;

  logic        vout32, rout32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic        vout64, rout64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(rout32),
    .instr_i(instr), .pc_i(pc32), .valid_o(vout32), .ready_i(rdy),
    .imm_o(imm32), .fmt_o(fmt32), .target_o(tgt32), .illegal_o(ill32)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(rout64),
    .instr_i(instr), .pc_i(pc64), .valid_o(vout64), .ready_i(rdy),
    .imm_o(imm64), .fmt_o(fmt64), .target_o(tgt64), .illegal_o(ill64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int total = 0;
  int bad = 0;

  localparam longint P31 = 64'sh8000_0000;
  localparam longint P32 = 64'sh1_0000_0000;

  // Reference: immediate value computed arithmetically from the field weights
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] p, input int xlen);
    exp_t e;
    longint v;
    logic [63:0] mask;
    logic [2:0] f3;
    f3 = ins[14:12];
    v = 0;
    e.fmt = FMT_NONE;
    e.ill = 1'b0;
    case (ins[6:0])
      7'b0000011, 7'b1100111, 7'b1110011: begin
        e.fmt = FMT_I; v = longint'(ins[31:20]); if (v >= 2048) v -= 4096;
      end
      7'b0010011: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.fmt = FMT_SH;
          v = (xlen == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
        end else begin
          e.fmt = FMT_I; v = longint'(ins[31:20]); if (v >= 2048) v -= 4096;
        end
      end
      7'b0100011: begin
        e.fmt = FMT_S; v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'b1100011: begin
        e.fmt = FMT_B;
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = FMT_U; v = longint'(ins[31:12]) * 4096; if (v >= P31) v -= P32;
      end
      7'b1101111: begin
        e.fmt = FMT_J;
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      7'b0110011, 7'b0001111: e.fmt = FMT_NONE;
      default: e.ill = 1'b1;
    endcase
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    e.imm = 64'(v) & mask;
    e.tgt = (p + 64'(v)) & mask;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("valid_o32", 64'(vout32), 64'(q32.size() > 0));
    chk("ready_o32", 64'(rout32), 64'(q32.size() < 2));
    chk("valid_o64", 64'(vout64), 64'(q64.size() > 0));
    chk("ready_o64", 64'(rout64), 64'(q64.size() < 2));
    if (q32.size() > 0) begin
      chk("imm32", 64'(imm32), q32[0].imm);
      chk("tgt32", 64'(tgt32), q32[0].tgt);
      chk("fmt32", 64'(fmt32), 64'(q32[0].fmt));
      chk("ill32", 64'(ill32), 64'(q32[0].ill));
    end
    if (q64.size() > 0) begin
      chk("imm64", imm64, q64[0].imm);
      chk("tgt64", tgt64, q64[0].tgt);
      chk("fmt64", 64'(fmt64), 64'(q64[0].fmt));
      chk("ill64", 64'(ill64), 64'(q64[0].ill));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid32"}, 64'(vout32), 64'd0);
    chk({tag, "_ready32"}, 64'(rout32), 64'd1);
    chk({tag, "_imm32"}, 64'(imm32), 64'd0);
    chk({tag, "_fmt32"}, 64'(fmt32), 64'd0);
    chk({tag, "_tgt32"}, 64'(tgt32), 64'd0);
    chk({tag, "_ill32"}, 64'(ill32), 64'd0);
    chk({tag, "_valid64"}, 64'(vout64), 64'd0);
    chk({tag, "_ready64"}, 64'(rout64), 64'd1);
    chk({tag, "_imm64"}, imm64, 64'd0);
    chk({tag, "_tgt64"}, tgt64, 64'd0);
  endtask

  // Called at a negative edge: drive one cycle of inputs, advance the model
  // by what that cycle should do, then check at the next negative edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] p,
                      input logic r, input logic f, output logic acc);
    int n;
    logic do_acc, do_pop;
    n = q32.size();
    vin = v; instr = ins; pc32 = p[31:0]; pc64 = p; rdy = r; flush = f;
    do_acc = v && (n < 2);
    do_pop = (n > 0) && r;
    acc = do_acc && !f;
    if (f) begin
      q32.delete();
      q64.delete();
    end else begin
      if (do_pop) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (do_acc) begin
        q32.push_back(model(ins, p, 32));
        q64.push_back(model(ins, p, 64));
      end
    end
    @(negedge clk);
    check_all();
  endtask

  logic        acc;
  logic        cur_v;
  logic [31:0] cur_ins;
  logic [63:0] cur_pc;
  logic [6:0]  opc_tab [12];
  logic [31:0] r;

  initial begin
    opc_tab = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011, 7'b1111111};
    rst_n = 1'b0; flush = 1'b0; vin = 1'b0; rdy = 1'b0;
    instr = '0; pc32 = '0; pc64 = '0;
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decodes with ready_i held high
    step(1'b1, 32'hFFF00093, 64'h100, 1'b1, 1'b0, acc);
    chk("addi_imm", 64'(imm32), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(fmt32), 64'(FMT_I));
    step(1'b1, 32'h123450B7, 64'h100, 1'b1, 1'b0, acc);
    chk("lui_imm", 64'(imm32), 64'h1234_5000);
    chk("lui_fmt", 64'(fmt32), 64'(FMT_U));
    step(1'b1, 32'h4030D093, 64'h100, 1'b1, 1'b0, acc);
    chk("srai_imm", 64'(imm32), 64'h3);
    chk("srai_fmt", 64'(fmt32), 64'(FMT_SH));
    step(1'b1, 32'h01F09093, 64'h100, 1'b1, 1'b0, acc);
    chk("slli_imm", 64'(imm32), 64'h1F);
    step(1'b1, 32'hFE000EE3, 64'h100, 1'b1, 1'b0, acc);
    chk("beq_imm", 64'(imm32), 64'hFFFF_FFFC);
    chk("beq_fmt", 64'(fmt32), 64'(FMT_B));
    chk("beq_tgt", 64'(tgt32), 64'hFC);
    step(1'b1, 32'h001000EF, 64'h100, 1'b1, 1'b0, acc);
    chk("jal_imm", 64'(imm32), 64'h800);
    chk("jal_tgt", 64'(tgt32), 64'h900);
    step(1'b1, 32'h0000007F, 64'h100, 1'b1, 1'b0, acc);
    chk("illegal_flag", 64'(ill32), 64'd1);
    chk("illegal_imm", 64'(imm32), 64'd0);
    step(1'b1, 32'h800000B7, 64'h0, 1'b1, 1'b0, acc);
    chk("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
    step(1'b1, 32'hFFC00093, 64'h0, 1'b1, 1'b0, acc);
    chk("wrap_tgt32", 64'(tgt32), 64'hFFFF_FFFC);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // Backpressure: three pushes, ready_o drops after the second accept
    step(1'b1, 32'hFFF00093, 64'h100, 1'b0, 1'b0, acc);
    chk("bp_ready_after1", 64'(rout32), 64'd1);
    step(1'b1, 32'h123450B7, 64'h104, 1'b0, 1'b0, acc);
    chk("bp_ready_after2", 64'(rout32), 64'd0);
    step(1'b1, 32'h4030D093, 64'h108, 1'b0, 1'b0, acc);
    step(1'b1, 32'h4030D093, 64'h108, 1'b0, 1'b0, acc);
    chk("bp_hold_imm", 64'(imm32), 64'hFFFF_FFFF);
    step(1'b1, 32'h4030D093, 64'h108, 1'b1, 1'b0, acc);
    chk("bp_second_imm", 64'(imm32), 64'h1234_5000);
    step(1'b1, 32'h4030D093, 64'h108, 1'b1, 1'b0, acc);
    chk("bp_third_imm", 64'(imm32), 64'h3);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // Flush with both entries full and a valid input
    step(1'b1, 32'h001000EF, 64'h200, 1'b0, 1'b0, acc);
    step(1'b1, 32'hFE000EE3, 64'h204, 1'b0, 1'b0, acc);
    step(1'b1, 32'h123450B7, 64'h208, 1'b0, 1'b1, acc);
    chk("flush_valid", 64'(vout32), 64'd0);
    chk("flush_ready", 64'(rout32), 64'd1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // Asynchronous reset in the middle of a stall
    step(1'b1, 32'hFFF00093, 64'h300, 1'b0, 1'b0, acc);
    step(1'b1, 32'h001000EF, 64'h304, 1'b0, 1'b0, acc);
    vin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    q32.delete();
    q64.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h01F09093, 64'h400, 1'b0, 1'b0, acc);
    chk("post_reset_imm", 64'(imm32), 64'h1F);

    // Random traffic; a held (unaccepted) input stays stable until taken
    cur_v = 1'b0; cur_ins = '0; cur_pc = '0;
    for (int i = 0; i < 400; i++) begin
      logic f;
      if (!cur_v || acc) begin
        r = $urandom();
        r[6:0] = opc_tab[$urandom_range(0, 11)];
        if (r[6:0] == 7'b1111111) r[6:0] = 7'($urandom());
        cur_ins = r;
        cur_pc = {32'($urandom()), 32'($urandom())};
        cur_v = ($urandom_range(0, 3) != 0);
      end
      f = ($urandom_range(0, 24) == 0);
      step(cur_v, cur_ins, cur_pc, 1'($urandom_range(0, 2) != 0), f, acc);
      if (f) acc = 1'b1;
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the pipelined RV32I/RV64I core, placed between instruction fetch and the ID/EX register. Decodes every base-ISA immediate format (I, shift, S, B, U, J) from a 32-bit instruction and sign-extends it to XLEN. Computes the PC-relative target for branch, JAL and AUIPC, and flags unknown opcodes. A two-entry valid/ready skid buffer provides one-cycle latency, full throughput under backpressure, and a synchronous flush for branch mispredicts.

## Interface
- XLEN, 32: datapath width. Only 32 or 64 are legal.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous kill of all buffered entries.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept; registered only.
- instr_i  in  32  instruction word.
- pc_i  in  XLEN  PC of instr_i.
- valid_o  out  1  output entry valid.
- ready_i  in  1  downstream accepts.
- imm_o  out  XLEN  sign-/zero-extended immediate.
- fmt_o  out  3  format code from the package.
- target_o  out  XLEN  pc + imm_o, modulo 2^XLEN.
- illegal_o  out  1  opcode not in the decode list.

## Operation
- Accept when valid_i && ready_o. Pop when valid_o && ready_i.
- Decode on opcode instr[6:0]. Every value is sign-extended from the MSB shown unless stated otherwise.
  - LOAD 0000011, JALR 1100111, SYSTEM 1110011: fmt I, imm = instr[31:20].
  - OP-IMM 0010011 with funct3 001 or 101: fmt SH, zero-extended shamt.
    - shamt = instr[24:20] when XLEN=32.
    - shamt = instr[25:20] when XLEN=64.
    - instr[30] is ignored.
  - Other OP-IMM: fmt I.
  - STORE 0100011: fmt S, imm = {instr[31:25], instr[11:7]}.
  - BRANCH 1100011: fmt B, imm = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - LUI 0110111 and AUIPC 0010111: fmt U, imm = {instr[31:12], 12'b0}; sign-extended when XLEN=64.
  - JAL 1101111: fmt J, imm = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - OP 0110011 and MISC-MEM 0001111: fmt NONE, imm = 0, illegal_o = 0.
  - Any other opcode: fmt NONE, imm = 0, illegal_o = 1.
- target_o = pc + imm for every entry. It is meaningful only for fmt B, J, and U with AUIPC.
- Buffer: main entry (drives outputs) plus a skid entry. ready_o = !skid_valid.
  - Accept with main empty, or with main popping and skid empty: write to main.
  - Accept while main is held (valid_o && !ready_i): write to skid.
  - Pop with skid full: skid moves to main, and skid clears.
- While valid_o && !ready_i, imm_o, fmt_o, target_o and illegal_o hold stable.
- Output order always equals acceptance order.

## Timing
- Latency is 1 cycle: accept in cycle N, valid_o in cycle N+1.
- Throughput is 1 per cycle while ready_i = 1.
- No combinational path from ready_i to ready_o, or from valid_i to valid_o.
- Reset (rst_i = 0, asynchronous):
  - Cleared to 0: valid_o, imm_o, fmt_o (NONE = 0), target_o, illegal_o, and both entry valids.
  - ready_o = 1.
- Reset mid-stall discards both entries immediately. The first accept after rst_i rises behaves as from empty.
- flush_i = 1 has priority over a simultaneous accept and a simultaneous pop. Next cycle: valid_o = 0, ready_o = 1, and the input in the flush cycle is dropped.
- Full buffer (skid_valid): ready_o = 0. Upstream must hold valid_i and instr_i.
- target_o wraps silently, e.g. pc 0x0 with imm −4 gives 0xFFFFFFFC when XLEN=32.

## Structure
- Shared riscv_pkg holds:
  - Opcode constants: OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_MISCMEM, OPC_SYSTEM.
  - Format codes: FMT_NONE = 0, FMT_I = 1, FMT_SH = 2, FMT_S = 3, FMT_B = 4, FMT_U = 5, FMT_J = 6.
- Combinational sub-module imm_decode is parametrised by XLEN:
  - Inputs: instr.
  - Outputs: imm, fmt, illegal.
- imm_gen_stage instantiates one imm_decode ahead of the buffer. The adder for target_o sits before the registers.

## Test plan
- XLEN=32, ready_i=1, pc 0x100:
  - addi 0xFFF00093 -> one cycle later imm_o=0xFFFFFFFF, fmt_o=I.
  - lui 0x123450B7 -> imm_o=0x12345000, fmt_o=U.
- Shifts: srai 0x4030D093 -> imm_o=0x3, fmt_o=SH. slli 0x01F09093 -> imm_o=0x1F.
- beq 0xFE000EE3, pc 0x100 -> imm_o=0xFFFFFFFC, fmt_o=B, target_o=0xFC. jal 0x001000EF, pc 0x100 -> imm_o=0x800, target_o=0x900.
- Backpressure: ready_i=0, push three instructions.
  - ready_o drops after the second accept.
  - Outputs are held stable.
  - After ready_i rises, all three emerge in order on consecutive cycles.
- flush_i with valid_i=1 and both entries full -> next cycle valid_o=0 and ready_o=1, and nothing from before the flush ever emerges.
- Opcode 0x0000007F -> illegal_o=1, imm_o=0.
- rst_i asserted mid-stall -> all outputs 0 without a clock edge.
- XLEN=64: lui 0x800000B7 -> imm_o=0xFFFFFFFF80000000.
